// File: rtl/rc4_phase_sequencer.sv
// rc4_phase_sequencer: top-level sequencer running the RC4 INIT -> SHUFFLE -> DECRYPT sub-FSMs
// and muxing their S-memory requests onto one port. Optional DECRYPT phase: `define DECRYPT_PHASE_EN.
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rc4_phase_sequencer                                             |
// | Brief  : phase sequencer with per-phase timeout and shared S-memory mux  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module rc4_phase_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       key_changed,
  output logic       init_start,
  output logic       shuf_start,
  output logic       dec_start,
  input  logic       init_done,
  input  logic       shuf_done,
  input  logic       dec_done,
  input  logic [7:0] init_addr,
  input  logic [7:0] shuf_addr,
  input  logic [7:0] dec_addr,
  input  logic [7:0] init_data,
  input  logic [7:0] shuf_data,
  input  logic [7:0] dec_data,
  input  logic       init_wren,
  input  logic       shuf_wren,
  input  logic       dec_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_data,
  output logic       s_wren,
  output logic       sub_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] phase
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_SHUF  = 3'd2;
  localparam logic [2:0] ST_DEC   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;
  localparam logic [2:0] ST_ABORT = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          active_q;
  logic          timeout_q;

  assign active_q  = (state_q == ST_INIT) || (state_q == ST_SHUF) || (state_q == ST_DEC);
  assign timeout_q = (timer_q >= TLIMIT);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Abort outranks everything outside IDLE; a phase's own done outranks its timeout.
  always_comb begin
    state_d = state_q;
    if (key_changed && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
      state_d = ST_ABORT;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_INIT;
        ST_INIT: begin
          if (init_done)      state_d = ST_SHUF;
          else if (timeout_q) state_d = ST_ERROR;
        end
        ST_SHUF: begin
`ifdef DECRYPT_PHASE_EN
          if (shuf_done)      state_d = ST_DEC;
`else
          if (shuf_done)      state_d = ST_DONE;
`endif
          else if (timeout_q) state_d = ST_ERROR;
        end
`ifdef DECRYPT_PHASE_EN
        ST_DEC: begin
          if (dec_done)       state_d = ST_DONE;
          else if (timeout_q) state_d = ST_ERROR;
        end
`endif
        ST_ABORT: state_d = ST_INIT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Timer restarts at every phase entry and saturates instead of wrapping.
  always_comb begin
    timer_d = '0;
    if (active_q && (state_d == state_q)) begin
      timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
    end
  end

  always_comb begin
    phase      = state_q;
    busy       = active_q || (state_q == ST_ABORT);
    done       = (state_q == ST_DONE);
    error      = (state_q == ST_ERROR);
    sub_reset  = (state_q == ST_ABORT);
    init_start = (state_q == ST_INIT) && (timer_q == '0);
    shuf_start = (state_q == ST_SHUF) && (timer_q == '0);
`ifdef DECRYPT_PHASE_EN
    dec_start  = (state_q == ST_DEC)  && (timer_q == '0);
`else
    dec_start  = 1'b0;
`endif
    s_addr = 8'h00;
    s_data = 8'h00;
    s_wren = 1'b0;
    case (state_q)
      ST_INIT: begin
        s_addr = init_addr;
        s_data = init_data;
        s_wren = init_wren;
      end
      ST_SHUF: begin
        s_addr = shuf_addr;
        s_data = shuf_data;
        s_wren = shuf_wren;
      end
`ifdef DECRYPT_PHASE_EN
      ST_DEC: begin
        s_addr = dec_addr;
        s_data = dec_data;
        s_wren = dec_wren;
      end
`endif
      default: ;
    endcase
  end

`ifndef DECRYPT_PHASE_EN
  logic w_unused_dec;
  assign w_unused_dec = ^{dec_done, dec_addr, dec_data, dec_wren};
`endif

endmodule
`default_nettype wire
